// File: rtl/uart_sdram_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_sdram_cmd_bridge                                                    |
// | UART byte-command parser issuing SDRAM word reads/writes with replies.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module uart_sdram_cmd_bridge #(
    parameter int IADDR_WIDTH    = 22,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 13_300_000
) (
    input  logic                   i_sys_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_rdy,
    output logic                   o_rx_req,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_req,
    input  logic                   i_tx_rdy,
    output logic                   o_wr_req,
    output logic [IADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]  o_wr_data,
    output logic                   o_rd_req,
    output logic [IADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_rd_data,
    input  logic                   i_rd_rdy,
    output logic                   o_busy
);

    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]         c_OP_WR    = 8'h77;
    localparam logic [7:0]         c_OP_RD    = 8'h72;
    localparam logic [7:0]         c_RSP_BAD  = 8'h3F;
    localparam logic [7:0]         c_RSP_OK   = 8'h4B;
    localparam logic [7:0]         c_RSP_TMO  = 8'h21;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_ADDR  = 4'd1,
        S_R_ADDR  = 4'd2,
        S_W_DATA  = 4'd3,
        S_W_ISSUE = 4'd4,
        S_R_ISSUE = 4'd5,
        S_R_WAIT  = 4'd6,
        S_TX      = 4'd7
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_cnt;
    logic [IADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [c_TMO_W-1:0]      r_tmo;
    logic [DATA_WIDTH-1:0]   r_tx_buf;
    logic [1:0]              r_tx_left;
    logic                    r_tx_guard;

    logic w_rx_open;
    logic w_rx_take;
    logic w_tmo_hit;

    // o_rx_req high means a byte was taken last cycle; that byte may still be presented.
    assign w_rx_open = (r_state == S_IDLE) || (r_state == S_W_ADDR) ||
                       (r_state == S_R_ADDR) || (r_state == S_W_DATA);
    assign w_rx_take = i_rx_rdy && !o_rx_req && w_rx_open;
    assign w_tmo_hit = (r_tmo == c_TMO_LAST);
    assign o_busy    = (r_state != S_IDLE);

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tmo      <= '0;
            r_tx_buf   <= '0;
            r_tx_left  <= 2'd0;
            r_tx_guard <= 1'b0;
            o_rx_req   <= 1'b0;
            o_tx_data  <= 8'h00;
            o_tx_req   <= 1'b0;
            o_wr_req   <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_rd_req   <= 1'b0;
            o_rd_addr  <= '0;
        end else begin
            o_rx_req <= 1'b0;
            o_tx_req <= 1'b0;
            o_wr_req <= 1'b0;
            o_rd_req <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_take) begin
                        o_rx_req <= 1'b1;
                        r_cnt    <= 2'd0;
                        r_tmo    <= '0;
                        if (i_rx_data == c_OP_WR) begin
                            r_state <= S_W_ADDR;
                        end else if (i_rx_data == c_OP_RD) begin
                            r_state <= S_R_ADDR;
                        end else begin
                            r_tx_buf  <= {c_RSP_BAD, 8'h00};
                            r_tx_left <= 2'd1;
                            r_state   <= S_TX;
                        end
                    end
                end

                S_W_ADDR, S_R_ADDR: begin
                    if (w_rx_take) begin
                        o_rx_req <= 1'b1;
                        r_tmo    <= '0;
                        // Shifting through a register of the address width drops the upper A2 bits.
                        r_addr   <= {r_addr[IADDR_WIDTH-9:0], i_rx_data};
                        if (r_cnt == 2'd2) begin
                            r_cnt   <= 2'd0;
                            r_state <= (r_state == S_W_ADDR) ? S_W_DATA : S_R_ISSUE;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end else if (w_tmo_hit) begin
                        r_tx_buf  <= {c_RSP_TMO, 8'h00};
                        r_tx_left <= 2'd1;
                        r_state   <= S_TX;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end

                S_W_DATA: begin
                    if (w_rx_take) begin
                        o_rx_req <= 1'b1;
                        r_tmo    <= '0;
                        r_data   <= {r_data[DATA_WIDTH-9:0], i_rx_data};
                        if (r_cnt == 2'd1) begin
                            r_cnt   <= 2'd0;
                            r_state <= S_W_ISSUE;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end else if (w_tmo_hit) begin
                        r_tx_buf  <= {c_RSP_TMO, 8'h00};
                        r_tx_left <= 2'd1;
                        r_state   <= S_TX;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end

                S_W_ISSUE: begin
                    o_wr_req  <= 1'b1;
                    o_wr_addr <= r_addr;
                    o_wr_data <= r_data;
                    r_tx_buf  <= {c_RSP_OK, 8'h00};
                    r_tx_left <= 2'd1;
                    r_state   <= S_TX;
                end

                S_R_ISSUE: begin
                    o_rd_req  <= 1'b1;
                    o_rd_addr <= r_addr;
                    r_tmo     <= '0;
                    r_state   <= S_R_WAIT;
                end

                S_R_WAIT: begin
                    if (i_rd_rdy) begin
                        r_tx_buf  <= i_rd_data;
                        r_tx_left <= 2'd2;
                        r_state   <= S_TX;
                    end else if (w_tmo_hit) begin
                        r_tx_buf  <= {c_RSP_TMO, 8'h00};
                        r_tx_left <= 2'd1;
                        r_state   <= S_TX;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end

                S_TX: begin
                    // The cycle after a pulse i_tx_rdy may still show the pre-start value.
                    if (r_tx_guard) begin
                        r_tx_guard <= 1'b0;
                    end else if (r_tx_left == 2'd0) begin
                        r_state <= S_IDLE;
                    end else if (i_tx_rdy) begin
                        o_tx_req   <= 1'b1;
                        o_tx_data  <= r_tx_buf[DATA_WIDTH-1 -: 8];
                        r_tx_buf   <= {r_tx_buf[DATA_WIDTH-9:0], 8'h00};
                        r_tx_left  <= r_tx_left - 2'd1;
                        r_tx_guard <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_sdram_cmd_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_sdram_cmd_bridge                                                 |
// | Command-table and random-command bench for the UART/SDRAM bridge.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_uart_sdram_cmd_bridge;

    localparam int TMO = 50;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_req;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_rdy;
    logic        wr_req;
    logic [21:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_rdy;
    logic        busy;

    uart_sdram_cmd_bridge #(
        .IADDR_WIDTH    (22),
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_sys_clk (clk),
        .i_rst     (rst),
        .i_rx_data (rx_data),
        .i_rx_rdy  (rx_rdy),
        .o_rx_req  (rx_req),
        .o_tx_data (tx_data),
        .o_tx_req  (tx_req),
        .i_tx_rdy  (tx_rdy),
        .o_wr_req  (wr_req),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_rd_req  (rd_req),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .i_rd_rdy  (rd_rdy),
        .o_busy    (busy)
    );

    typedef struct packed {
        logic [47:0] bytes;
        int          n;
        int          rd_dly;
        logic        exp_wr;
        logic [21:0] wr_addr;
        logic [15:0] wr_data;
        logic        exp_rd;
        logic [21:0] rd_addr;
        logic [15:0] rd_resp;
        int          n_tx;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
    } cmd_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rx_cnt   = 0;
    int          rx_cyc_last = 0;
    int          rd_cyc_last = 0;
    int          both_cnt = 0;
    logic [21:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [21:0] rd_q      [$];
    logic [7:0]  tx_q      [$];
    int          tx_cyc_q  [$];
    int          rd_delay    = 0;
    logic [15:0] rd_resp_val = 16'h0;
    bit          tx_stall    = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event log of every DUT output strobe
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_req) begin
                wr_addr_q.push_back(wr_addr);
                wr_data_q.push_back(wr_data);
            end
            if (rd_req) begin
                rd_q.push_back(rd_addr);
                rd_cyc_last = cyc;
            end
            if (tx_req) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
            end
            if (rx_req) begin
                rx_cnt++;
                rx_cyc_last = cyc;
            end
            if (wr_req && rd_req) both_cnt++;
        end
    end

    // SDRAM read responder; rd_delay of 0 means never answer
    initial begin
        rd_rdy  = 1'b0;
        rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (rd_req && rd_delay > 0) begin
                repeat (rd_delay - 1) @(negedge clk);
                rd_data = rd_resp_val;
                rd_rdy  = 1'b1;
                @(negedge clk);
                rd_rdy  = 1'b0;
                rd_data = 16'($urandom);
            end
        end
    end

    // UART transmitter: optionally busy for 4 cycles after each start
    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_stall && tx_req) begin
                tx_rdy = 1'b0;
                repeat (4) @(negedge clk);
                tx_rdy = 1'b1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold2);
        bit got;
        got = 1'b0;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rx_req) begin
                got = 1'b1;
                break;
            end
        end
        if (hold2) @(negedge clk);
        rx_rdy = 1'b0;
        if (!got) chk("rx_consume_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_cmd(input cmd_t c, input bit hold2, input bit chk_gap);
        int wb, rb, tb, xb, ob, ref_cyc;
        wb = wr_addr_q.size();
        rb = rd_q.size();
        tb = tx_q.size();
        xb = rx_cnt;
        ob = both_cnt;
        rd_resp_val = c.rd_resp;
        rd_delay    = c.rd_dly;
        for (int k = 0; k < c.n; k++) send_byte(c.bytes[47-8*k -: 8], hold2);
        wait_idle(300);
        repeat (6) @(negedge clk);

        chk("rx_pulses", 64'(rx_cnt - xb), 64'(c.n));
        chk("wr_count", 64'(wr_addr_q.size() - wb), 64'(c.exp_wr));
        if (c.exp_wr && wr_addr_q.size() > wb) begin
            chk("wr_addr", 64'(wr_addr_q[wb]), 64'(c.wr_addr));
            chk("wr_data", 64'(wr_data_q[wb]), 64'(c.wr_data));
        end
        chk("rd_count", 64'(rd_q.size() - rb), 64'(c.exp_rd));
        if (c.exp_rd && rd_q.size() > rb) chk("rd_addr", 64'(rd_q[rb]), 64'(c.rd_addr));
        chk("tx_count", 64'(tx_q.size() - tb), 64'(c.n_tx));
        if (tx_q.size() > tb) chk("tx_byte0", 64'(tx_q[tb]), 64'(c.tx0));
        if (c.n_tx == 2 && tx_q.size() > tb + 1) begin
            chk("tx_byte1", 64'(tx_q[tb+1]), 64'(c.tx1));
            if (chk_gap) chk("tx_guard_gap", 64'(tx_cyc_q[tb+1] - tx_cyc_q[tb]), 64'd2);
        end
        if (c.n_tx == 1 && c.tx0 == 8'h21 && tx_q.size() > tb) begin
            ref_cyc = c.exp_rd ? rd_cyc_last : rx_cyc_last;
            chk("tmo_latency_49_50",
                64'((tx_cyc_q[tb] - ref_cyc >= TMO - 1) && (tx_cyc_q[tb] - ref_cyc <= TMO)), 64'd1);
        end
        chk("wr_rd_overlap", 64'(both_cnt - ob), 64'd0);
    endtask

    // Reference model: decode a whole command from protocol rules
    function automatic cmd_t model(input logic [47:0] bytes, input int n, input int dly,
                                   input logic [15:0] resp);
        cmd_t m;
        int   a24;
        m         = '0;
        m.bytes   = bytes;
        m.n       = n;
        m.rd_dly  = dly;
        m.rd_resp = resp;
        a24       = int'(bytes[39:16]);
        if (bytes[47:40] == 8'h77 && n == 6) begin
            m.exp_wr  = 1'b1;
            m.wr_addr = 22'(a24 % (1 << 22));
            m.wr_data = bytes[15:0];
            m.n_tx    = 1;
            m.tx0     = 8'h4B;
        end else if (bytes[47:40] == 8'h72 && n == 4) begin
            m.exp_rd  = 1'b1;
            m.rd_addr = 22'(a24 % (1 << 22));
            if (dly > 0) begin
                m.n_tx = 2;
                m.tx0  = 8'(resp / 256);
                m.tx1  = 8'(resp % 256);
            end else begin
                m.n_tx = 1;
                m.tx0  = 8'h21;
            end
        end else begin
            m.n_tx = 1;
            m.tx0  = 8'h3F;
        end
        return m;
    endfunction

    cmd_t vecs [9];

    initial begin
        cmd_t        c;
        logic [47:0] rb;
        int          kind;
        int          tb0, wb0;

        vecs[0] = '{bytes: 48'h77_01_23_45_BE_EF, n: 6, rd_dly: 0, exp_wr: 1, wr_addr: 22'h012345,
                    wr_data: 16'hBEEF, exp_rd: 0, rd_addr: 0, rd_resp: 0, n_tx: 1, tx0: 8'h4B, tx1: 0};
        vecs[1] = '{bytes: 48'h72_3F_FF_FF_00_00, n: 4, rd_dly: 7, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 1, rd_addr: 22'h3FFFFF, rd_resp: 16'hA55A, n_tx: 2, tx0: 8'hA5, tx1: 8'h5A};
        vecs[2] = '{bytes: 48'h41_00_00_00_00_00, n: 1, rd_dly: 0, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 0, rd_addr: 0, rd_resp: 0, n_tx: 1, tx0: 8'h3F, tx1: 0};
        vecs[3] = '{bytes: 48'h77_FF_00_01_12_34, n: 6, rd_dly: 0, exp_wr: 1, wr_addr: 22'h3F0001,
                    wr_data: 16'h1234, exp_rd: 0, rd_addr: 0, rd_resp: 0, n_tx: 1, tx0: 8'h4B, tx1: 0};
        vecs[4] = '{bytes: 48'h72_C0_00_00_00_00, n: 4, rd_dly: 3, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 1, rd_addr: 22'h000000, rd_resp: 16'h0001, n_tx: 2, tx0: 8'h00, tx1: 8'h01};
        vecs[5] = '{bytes: 48'h77_01_00_00_00_00, n: 2, rd_dly: 0, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 0, rd_addr: 0, rd_resp: 0, n_tx: 1, tx0: 8'h21, tx1: 0};
        vecs[6] = '{bytes: 48'h72_12_34_56_00_00, n: 4, rd_dly: 1, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 1, rd_addr: 22'h123456, rd_resp: 16'h8000, n_tx: 2, tx0: 8'h80, tx1: 8'h00};
        vecs[7] = '{bytes: 48'h72_0A_BC_DE_00_00, n: 4, rd_dly: 0, exp_wr: 0, wr_addr: 0, wr_data: 0,
                    exp_rd: 1, rd_addr: 22'h0ABCDE, rd_resp: 0, n_tx: 1, tx0: 8'h21, tx1: 0};
        vecs[8] = '{bytes: 48'h77_00_00_00_00_00, n: 6, rd_dly: 0, exp_wr: 1, wr_addr: 22'h000000,
                    wr_data: 16'h0000, exp_rd: 0, rd_addr: 0, rd_resp: 0, n_tx: 1, tx0: 8'h4B, tx1: 0};

        rst     = 1'b1;
        rx_data = 8'h00;
        rx_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({rx_req, tx_req, wr_req, rd_req, busy, tx_data}), 64'd0);
        chk("rst_wr", 64'({wr_addr, wr_data}), 64'd0);
        chk("rst_rd", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Directed table, first with single-cycle rx_rdy, then held two cycles per byte
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 9; i++) run_cmd(vecs[i], bit'(p), 1'b1);

        // Transmitter busy between the two read-data bytes
        tx_stall = 1'b1;
        tb0 = tx_q.size();
        run_cmd(vecs[1], 1'b0, 1'b0);
        tx_stall = 1'b0;
        if (tx_q.size() > tb0 + 1) chk("tx_stall_gap", 64'(tx_cyc_q[tb0+1] - tx_cyc_q[tb0]), 64'd5);
        repeat (10) @(negedge clk);

        // Reset in the middle of a write command
        send_byte(8'h77, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h23, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctrl", 64'({rx_req, tx_req, wr_req, rd_req, busy, tx_data}), 64'd0);
        chk("midrst_wr", 64'({wr_addr, wr_data}), 64'd0);
        chk("midrst_rd", 64'(rd_addr), 64'd0);
        tb0 = tx_q.size();
        wb0 = wr_addr_q.size();
        repeat (TMO + 30) @(negedge clk);
        chk("midrst_no_tx", 64'(tx_q.size() - tb0), 64'd0);
        chk("midrst_no_wr", 64'(wr_addr_q.size() - wb0), 64'd0);
        run_cmd(model(48'h77_45_67_89_CA_FE, 6, 0, 16'h0), 1'b0, 1'b1);

        // Random commands against the reference model
        for (int i = 0; i < 24; i++) begin
            rb   = {$urandom, $urandom};
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                rb[47:40] = 8'h77;
                c = model(rb, 6, 0, 16'h0);
            end else if (kind == 1) begin
                rb[47:40] = 8'h72;
                c = model(rb, 4, int'($urandom_range(1, 10)), 16'($urandom));
            end else begin
                if (rb[47:40] == 8'h77 || rb[47:40] == 8'h72) rb[47:40] = 8'hA0;
                c = model(rb, 1, 0, 16'h0);
            end
            run_cmd(c, bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
